// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory controller: access sizes, FSM state
// encoding, default parameters and the captured request record.
package dmem_pkg;

    localparam int unsigned DEF_DEPTH_WORDS = 256;
    localparam int unsigned DEF_WAIT_CYCLES = 0;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store write mask and data replication,
// load lane selection with sign/zero extension, and misalignment detection.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata_word,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata_word[7:0];
            2'd1:    w_byte = i_rdata_word[15:8];
            2'd2:    w_byte = i_rdata_word[23:16];
            default: w_byte = i_rdata_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata_word[31:16] : i_rdata_word[15:0];

        o_wmask = 4'b0000;
        o_wdata = '0;
        o_rdata = '0;
        // Data is replicated to every lane; the mask alone decides what lands.
        case (i_size)
            SIZE_BYTE: begin
                o_wmask = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                o_wmask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
            end
            SIZE_WORD: begin
                o_wmask = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata_word;
            end
            default: begin
                o_wmask = 4'b0000;
            end
        endcase

        o_misaligned = ((i_size == SIZE_HALF) && i_addr_lo[0])
                    || ((i_size == SIZE_WORD) && (i_addr_lo != 2'b00));
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data-memory controller with WAIT_CYCLES wait states and one-cycle responses.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning down.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [1:0] ST_AFTER_ACCEPT = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    dmem_req_t   r_req;
    dmem_req_t   w_new_req;
    dmem_req_t   w_acc_req;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_oob;
    logic             w_misaligned;
    logic             w_err;
    logic             w_mem_we;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_wmask;
    logic [31:0]      w_wdata_lane;
    logic [31:0]      w_rdata_word;
    logic [31:0]      w_rdata_ext;

    assign req_ready = (r_state != ST_WAIT);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

    assign w_accept  = req_valid & req_ready;
    assign w_new_req = '{we: req_we, size: req_size, is_unsigned: req_unsigned,
                         addr: req_addr, wdata: req_wdata};

    // With no wait states the access completes on the accept edge itself,
    // so it must use the live request rather than the captured copy.
    assign w_acc_req    = (r_state == ST_WAIT) ? r_req : w_new_req;
    assign w_enter_resp = (r_state == ST_WAIT) ? (r_cnt == 4'd0)
                                               : (w_accept && (WAIT_CYCLES == 0));

    assign w_idx        = w_acc_req.addr[IDX_W+1:2];
    assign w_oob        = ({2'b00, w_acc_req.addr[31:2]} >= DEPTH_WORDS);
    assign w_rdata_word = r_mem[w_idx];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_err = (w_acc_req.size == SIZE_RSVD) | w_oob | w_misaligned;
`else
    logic w_unused_misaligned;
    assign w_unused_misaligned = w_misaligned;
    assign w_err = (w_acc_req.size == SIZE_RSVD) | w_oob;
`endif

    // Gating with rst_n keeps an access accepted during reset from committing.
    assign w_mem_we = w_enter_resp & w_acc_req.we & ~w_err & rst_n;

    dmem_lane_align u_lane_align (
        .i_size       (w_acc_req.size),
        .i_addr_lo    (w_acc_req.addr[1:0]),
        .i_unsigned   (w_acc_req.is_unsigned),
        .i_wdata      (w_acc_req.wdata),
        .i_rdata_word (w_rdata_word),
        .o_wmask      (w_wmask),
        .o_wdata      (w_wdata_lane),
        .o_rdata      (w_rdata_ext),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    w_state_next = ST_AFTER_ACCEPT;
                    w_cnt_next   = CNT_INIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_req       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            if (w_accept) begin
                r_req <= w_new_req;
            end
            r_rsp_valid <= w_enter_resp;
            r_rsp_err   <= w_enter_resp & w_err;
            r_rsp_rdata <= (w_enter_resp && !w_acc_req.we && !w_err) ? w_rdata_ext : '0;
        end
    end

    // Memory contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
                end
            end
        end
    end

endmodule
